verifier_sumcheck_round: RTL
============================

// Module: verifier_sumcheck_round
// PURPOSE
//  Verifier-side consumer of one sumcheck round: takes the prover's H(0), H(1), H(2) and the running claim.
//  Checks H(0)+H(1) == claim, then evaluates the degree-2 H at the verifier's random tau.
//  The result is the claim for the next round.
//  Sits in the verifier round loop, fed by the prover-to-verifier channel; output feeds back as next claim.
// PARAMETERS
//  CHECK_SUM  1  1: compute ok from the sum check; 0: skip the sum add, ok forced 1 (first round, claim unknown).
//  (field width `F_NBITS and modulus `F_Q are taken from field_arith_defs.v, not parameters)
// PORTS
//  clk          in   1         clock
//  rstb         in   1         reset, asynchronous, active-low
//  en           in   1         start pulse; h0/h1/h2/claim/tau sampled on this cycle
//  h0,h1,h2     in   F_NBITS   prover evaluations H(0),H(1),H(2), canonical (< F_Q)
//  claim        in   F_NBITS   claim from previous round
//  tau          in   F_NBITS   verifier challenge for this round
//  ready        out  1         high when idle/done; low while computing
//  ready_pulse  out  1         one-cycle pulse when htau/ok become valid
//  ok           out  1         H(0)+H(1)==claim (mod F_Q)
//  htau         out  F_NBITS   H(tau) mod F_Q
// BEHAVIOUR
//  Reset: ready=1, ready_pulse=0, ok=0, htau=0, FSM in IDLE, all internal registers cleared.
//  Algorithm (Newton form): d1=h1-h0; d2=h2-2*h1+h0; H(tau)=h0 + tau*d1 + (tau*(tau-1)*INV2)*d2.
//  INV2 = (F_Q+1)/2.
//  neg(x) is combinational: x==0 ? 0 : F_Q-x; subtraction is a + neg(b).
//  One field_adder and one field_multiplier, time-shared.
//  Each op: drive operands, pulse the unit's en for 1 cycle, wait for its ready_pulse, then latch the result.
//  FSM: IDLE -> SUM -> D1 -> S02 -> H2X -> D2 -> TM1 -> M_TT -> M_HALF -> M_D2 -> M_D1 -> ACC0 -> ACC1 -> DONE -> IDLE.
//   SUM    a=h0+h1; ok <= (a==claim_q) at DONE (skipped when CHECK_SUM=0)
//   D1     d1=h1+neg(h0)
//   S02    s=h2+h0
//   H2X    t=h1+h1
//   D2     d2=s+neg(t)
//   TM1    tm1=tau+neg(1)
//   M_TT   p=tau*tm1
//   M_HALF q=p*INV2
//   M_D2   r=q*d2
//   M_D1   u=tau*d1
//   ACC0   w=h0+u
//   ACC1   htau_n=w+r
//   DONE   htau, ok update; ready=1; ready_pulse=1 for exactly 1 cycle; return to IDLE
//  Latency: en to ready_pulse = 8 adds + 4 muls, each (1 + unit latency) cycles, + 1 (DONE).
//  ready falls the cycle after en.
//  en while ready=0 is ignored: inputs not resampled, no restart.
//  en in the same cycle as ready_pulse is accepted: back-to-back rounds allowed.
//  htau/ok hold their last values until the next DONE; they are not cleared on en.
//  Operands are registered at en, so input changes after the en cycle have no effect.
//  Reset mid-operation: abort immediately to reset state; no ready_pulse. Sub-units are reset by the same rstb.
//  All intermediates are canonical (< F_Q).
//  ok compares canonical values. ok is 0 when the claim is non-canonical (claim >= F_Q).
// STRUCTURE
//  Shared package / defs: F_Q, INV2 constant, FSM state enum (typedef), field_neg function.
//  Sub-modules: instantiates field_adder and field_multiplier unchanged.
//  Natural sub-module: verifier_quad_eval.
//   It holds the d1/d2/tau datapath (TM1..ACC1); the top keeps the sum check and handshake.
// TESTING
//  1 h0=3,h1=5,h2=9,claim=8,tau=4 -> ok=1, htau=23; exactly one ready_pulse.
//  2 Same H and tau, claim=7 -> ok=0, htau=23.
//  3 tau=0/1/2 with H as in test 1 -> htau=3/5/9 respectively.
//  4 Wrap-around: h0=0, h1=F_Q-1, h2=F_Q-2, claim=F_Q-1, tau=5 -> ok=1, htau=F_Q-5.
//  5 Second en while busy -> ignored, result matches first inputs.
//  5a en on the ready_pulse cycle -> second round runs and its result is correct.
//  6 rstb low mid-M_D2 -> ready=1, ok=0, htau=0, no pulse; next en gives correct result.
//  Run tests 1-3 with CHECK_SUM=0 -> ok=1.
//  Scoreboard: a Python/bignum model of H(tau) mod F_Q over random h0..h2/tau/claim.

Source files
------------

// File: rtl/verifier_sumcheck_round_pkg.sv
// Shared field constants, FSM state encoding and field helpers for the sumcheck round verifier.
package verifier_sumcheck_round_pkg;

    localparam int unsigned F_NBITS = 32;
    typedef logic [F_NBITS-1:0] fe_t;

    // Largest 32-bit prime; INV2 is the multiplicative inverse of 2 mod F_Q.
    localparam fe_t F_Q  = 32'hFFFF_FFFB;
    localparam fe_t INV2 = (F_Q + 32'd1) / 32'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_SUM, S_D1, S_S02, S_H2X, S_D2, S_TM1,
        S_M_TT, S_M_HALF, S_M_D2, S_M_D1, S_ACC0, S_ACC1, S_DONE
    } state_t;

    function automatic fe_t field_neg(input fe_t x);
        return (x == '0) ? '0 : F_Q - x;
    endfunction

endpackage

// File: rtl/verifier_sumcheck_round_if.sv
// Prover-to-verifier round channel: round inputs in, H(tau)/sum-check result out.
interface verifier_sumcheck_round_if;
    import verifier_sumcheck_round_pkg::*;

    logic en;
    fe_t  h0;
    fe_t  h1;
    fe_t  h2;
    fe_t  claim;
    fe_t  tau;
    logic ready;
    logic ready_pulse;
    logic ok;
    fe_t  htau;

    modport master (output en, h0, h1, h2, claim, tau,
                    input  ready, ready_pulse, ok, htau);
    modport slave  (input  en, h0, h1, h2, claim, tau,
                    output ready, ready_pulse, ok, htau);
endinterface

// File: rtl/field_adder.sv
// Modular adder: c = (a + b) mod F_Q for canonical inputs, one cycle after en.
module field_adder
    import verifier_sumcheck_round_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  fe_t  a,
    input  fe_t  b,
    output fe_t  c,
    output logic ready_pulse
);
    logic [F_NBITS:0] sum;
    fe_t  c_d, c_q;
    logic rp_d, rp_q;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        c_d  = c_q;
        rp_d = en;
        if (en) begin
            c_d = (sum >= {1'b0, F_Q}) ? fe_t'(sum - {1'b0, F_Q}) : sum[F_NBITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            c_q  <= '0;
            rp_q <= 1'b0;
        end else begin
            c_q  <= c_d;
            rp_q <= rp_d;
        end
    end

    assign c           = c_q;
    assign ready_pulse = rp_q;
endmodule

// File: rtl/field_multiplier.sv
// Modular multiplier: c = (a * b) mod F_Q, two cycles after en (product, then reduction).
module field_multiplier
    import verifier_sumcheck_round_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  fe_t  a,
    input  fe_t  b,
    output fe_t  c,
    output logic ready_pulse
);
    logic [2*F_NBITS-1:0] prod_d, prod_q;
    logic v1_d, v1_q;
    fe_t  c_d, c_q;
    logic rp_d, rp_q;

    always_comb begin
        prod_d = prod_q;
        v1_d   = en;
        c_d    = c_q;
        rp_d   = v1_q;
        if (en) begin
            prod_d = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
        end
        if (v1_q) begin
            c_d = fe_t'(prod_q % {{F_NBITS{1'b0}}, F_Q});
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            c_q    <= '0;
            rp_q   <= 1'b0;
        end else begin
            prod_q <= prod_d;
            v1_q   <= v1_d;
            c_q    <= c_d;
            rp_q   <= rp_d;
        end
    end

    assign c           = c_q;
    assign ready_pulse = rp_q;
endmodule

// File: rtl/verifier_sumcheck_round_quad_eval.sv
// verifier_quad_eval: holds d1/d2/tau and the Newton-form intermediates, supplies shared-unit operands for TM1..ACC1.
module verifier_quad_eval
    import verifier_sumcheck_round_pkg::*;
(
    input  logic   clk,
    input  logic   rstb,
    input  state_t state,
    input  logic   start,
    input  fe_t    tau_in,
    input  fe_t    h0_in,
    input  fe_t    res,
    input  logic   latch,
    output fe_t    add_a,
    output fe_t    add_b,
    output fe_t    mul_a,
    output fe_t    mul_b
);
    fe_t tau_d, tau_q, d1_d, d1_q, d2_d, d2_q, tm1_d, tm1_q;
    fe_t p_d, p_q, q_d, q_q, r_d, r_q, u_d, u_q, w_d, w_q;

    always_comb begin
        tau_d = tau_q; d1_d = d1_q; d2_d = d2_q; tm1_d = tm1_q;
        p_d = p_q; q_d = q_q; r_d = r_q; u_d = u_q; w_d = w_q;
        add_a = '0; add_b = '0; mul_a = '0; mul_b = '0;
        if (start) tau_d = tau_in;
        if (latch) begin
            case (state)
                S_D1:     d1_d  = res;
                S_D2:     d2_d  = res;
                S_TM1:    tm1_d = res;
                S_M_TT:   p_d   = res;
                S_M_HALF: q_d   = res;
                S_M_D2:   r_d   = res;
                S_M_D1:   u_d   = res;
                S_ACC0:   w_d   = res;
                default:  ;
            endcase
        end
        case (state)
            S_TM1:    begin add_a = tau_q; add_b = field_neg(fe_t'(1)); end
            S_ACC0:   begin add_a = h0_in; add_b = u_q;                 end
            S_ACC1:   begin add_a = w_q;   add_b = r_q;                 end
            S_M_TT:   begin mul_a = tau_q; mul_b = tm1_q;               end
            S_M_HALF: begin mul_a = p_q;   mul_b = INV2;                end
            S_M_D2:   begin mul_a = q_q;   mul_b = d2_q;                end
            S_M_D1:   begin mul_a = tau_q; mul_b = d1_q;                end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tau_q <= '0; d1_q <= '0; d2_q <= '0; tm1_q <= '0;
            p_q <= '0; q_q <= '0; r_q <= '0; u_q <= '0; w_q <= '0;
        end else begin
            tau_q <= tau_d; d1_q <= d1_d; d2_q <= d2_d; tm1_q <= tm1_d;
            p_q <= p_d; q_q <= q_d; r_q <= r_d; u_q <= u_d; w_q <= w_d;
        end
    end
endmodule

// File: rtl/verifier_sumcheck_round.sv
// Verifier sumcheck round: checks H(0)+H(1)==claim and evaluates degree-2 H at tau
// using one time-shared field adder and multiplier.
module verifier_sumcheck_round
    import verifier_sumcheck_round_pkg::*;
#(
    parameter bit CHECK_SUM = 1'b1
) (
    input logic clk,
    input logic rstb,
    verifier_sumcheck_round_if.slave bus
);
    state_t state_d, state_q;
    logic   busy_d, busy_q;
    fe_t    h0_d, h0_q, h1_d, h1_q, h2_d, h2_q, claim_d, claim_q;
    fe_t    a_d, a_q, s_d, s_q, t_d, t_q, htau_d, htau_q;
    logic   ok_d, ok_q;

    logic ready, start, is_mul, add_en, mul_en, add_rp, mul_rp, latch;
    fe_t  add_a, add_b, add_c, mul_c, res;
    fe_t  qe_add_a, qe_add_b, qe_mul_a, qe_mul_b;

    always_comb begin
        ready  = (state_q == S_IDLE) || (state_q == S_DONE);
        start  = bus.en && ready;
        is_mul = state_q inside {S_M_TT, S_M_HALF, S_M_D2, S_M_D1};
        // Each op issues once, then waits (busy) for the unit's pulse before advancing.
        add_en = !ready && !is_mul && !busy_q;
        mul_en = !ready &&  is_mul && !busy_q;
        res    = is_mul ? mul_c : add_c;
        latch  = busy_q && (is_mul ? mul_rp : add_rp);

        busy_d = busy_q;
        if (add_en || mul_en) busy_d = 1'b1;
        if (latch)            busy_d = 1'b0;

        case (state_q)
            S_SUM:   begin add_a = h0_q; add_b = h1_q;            end
            S_D1:    begin add_a = h1_q; add_b = field_neg(h0_q); end
            S_S02:   begin add_a = h2_q; add_b = h0_q;            end
            S_H2X:   begin add_a = h1_q; add_b = h1_q;            end
            S_D2:    begin add_a = s_q;  add_b = field_neg(t_q);  end
            default: begin add_a = qe_add_a; add_b = qe_add_b;    end
        endcase

        state_d = state_q;
        h0_d = h0_q; h1_d = h1_q; h2_d = h2_q; claim_d = claim_q;
        a_d = a_q; s_d = s_q; t_d = t_q; htau_d = htau_q; ok_d = ok_q;

        if (ready) begin
            if (start) begin
                state_d = CHECK_SUM ? S_SUM : S_D1;
                h0_d = bus.h0; h1_d = bus.h1; h2_d = bus.h2; claim_d = bus.claim;
            end else if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
        end else if (latch) begin
            state_d = state_t'(state_q + 4'd1);
            case (state_q)
                S_SUM: a_d = res;
                S_S02: s_d = res;
                S_H2X: t_d = res;
                // Results are published on entry to DONE so they are valid with ready_pulse.
                S_ACC1: begin
                    htau_d = res;
                    ok_d   = CHECK_SUM ? (a_q == claim_q) : 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE; busy_q <= 1'b0;
            h0_q <= '0; h1_q <= '0; h2_q <= '0; claim_q <= '0;
            a_q <= '0; s_q <= '0; t_q <= '0; htau_q <= '0; ok_q <= 1'b0;
        end else begin
            state_q <= state_d; busy_q <= busy_d;
            h0_q <= h0_d; h1_q <= h1_d; h2_q <= h2_d; claim_q <= claim_d;
            a_q <= a_d; s_q <= s_d; t_q <= t_d; htau_q <= htau_d; ok_q <= ok_d;
        end
    end

    field_adder u_add (
        .clk(clk), .rstb(rstb), .en(add_en), .a(add_a), .b(add_b),
        .c(add_c), .ready_pulse(add_rp)
    );

    field_multiplier u_mul (
        .clk(clk), .rstb(rstb), .en(mul_en), .a(qe_mul_a), .b(qe_mul_b),
        .c(mul_c), .ready_pulse(mul_rp)
    );

    verifier_quad_eval u_quad (
        .clk(clk), .rstb(rstb), .state(state_q), .start(start),
        .tau_in(bus.tau), .h0_in(h0_q), .res(res), .latch(latch),
        .add_a(qe_add_a), .add_b(qe_add_b), .mul_a(qe_mul_a), .mul_b(qe_mul_b)
    );

    assign bus.ready       = ready;
    assign bus.ready_pulse = (state_q == S_DONE);
    assign bus.ok          = ok_q;
    assign bus.htau        = htau_q;
endmodule
